// File: rtl/inst_issue_queue_if.sv
// Handshake and status bundle between the instruction source/pipeline and the issue queue.
interface inst_issue_queue_if #(
    parameter int unsigned AW = 2,
    parameter int unsigned CW = 16
);
    logic          in_valid;
    logic [7:0]    in_inst;
    logic          in_ready;
    logic          issue_en;
    logic          flush;
    logic [7:0]    issue_inst;
    logic          issue_write;
    logic [AW:0]   count;
    logic          pipe_idle;
    logic [CW-1:0] issued_cnt;

    // Source/pipeline side
    modport master (
        output in_valid, in_inst, issue_en, flush,
        input  in_ready, issue_inst, issue_write, count, pipe_idle, issued_cnt
    );

    // Queue side
    modport slave (
        input  in_valid, in_inst, issue_en, flush,
        output in_ready, issue_inst, issue_write, count, pipe_idle, issued_cnt
    );
endinterface

// File: rtl/inst_issue_queue.sv
// Instruction issue queue: buffers 8-bit instructions and issues one per cycle (NOP when
// empty, held or flushed), shadowing the pipeline's EX/WB write-enables for pipe_idle.
module inst_issue_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2,
    parameter int unsigned CW    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    inst_issue_queue_if.slave     bus
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    logic          r_ex_sh;
    logic          r_wb_sh;
    logic [CW-1:0] r_issued_cnt;

    logic          w_in_ready;
    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_issue_inst;
    logic          w_issue_write;

    // Handshake, pop decision and issue mux; reset forces a NOP and refuses input
    always_comb begin
        w_in_ready    = i_rst && !bus.flush && (r_count != FULL_CNT);
        w_push        = bus.in_valid && w_in_ready;
        w_pop         = i_rst && bus.issue_en && !bus.flush && (r_count != '0);
        w_issue_inst  = w_pop ? r_mem[r_head] : 8'h00;
        w_issue_write = (w_issue_inst[7:6] != 2'b00);
    end

    // Storage array; contents need no reset since count gates every read
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_tail] <= bus.in_inst;
        end
    end

    // Pointers and occupancy; flush empties the queue and drops the same-cycle push
    always_ff @(posedge i_clk) begin
        if (!i_rst || bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // EX/WB write shadows; kept through flush because in-flight writes still land
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_ex_sh <= 1'b0;
            r_wb_sh <= 1'b0;
        end else begin
            r_ex_sh <= w_issue_write;
            r_wb_sh <= r_ex_sh;
        end
    end

    // Count of issued register-writing instructions, wrapping at 2^CW
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_issued_cnt <= '0;
        end else if (w_pop && w_issue_write) begin
            r_issued_cnt <= r_issued_cnt + 1'b1;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.issue_inst  = w_issue_inst;
    assign bus.issue_write = w_issue_write;
    assign bus.count       = r_count;
    assign bus.issued_cnt  = r_issued_cnt;
    assign bus.pipe_idle   = i_rst && (r_count == '0) && !w_issue_write && !r_ex_sh && !r_wb_sh;
endmodule

// File: tb/tb_inst_issue_queue.sv
// Directed bench for inst_issue_queue: reset, issue latency, full/back-pressure,
// flush, FIFO order across pointer wrap, and issued_cnt wrap.
module tb_inst_issue_queue;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    inst_issue_queue_if #(.AW(2), .CW(16)) bus ();

    inst_issue_queue #(.DEPTH(4), .AW(2), .CW(16)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after a rising edge, then wait to the falling edge for checks
    task automatic drive(input logic v, input logic [7:0] inst, input logic en, input logic fl);
        @(posedge clk);
        #1;
        bus.in_valid = v;
        bus.in_inst  = inst;
        bus.issue_en = en;
        bus.flush    = fl;
        @(negedge clk);
    endtask

    logic [7:0] stream [10];

    initial begin
        n_checks = 0;
        n_errors = 0;
        stream = '{8'h71, 8'h46, 8'h00, 8'h9B, 8'hE4, 8'h12, 8'h5A, 8'hA5, 8'h3C, 8'hC3};

        // 1: reset hold with active inputs, then release
        rst          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_inst  = 8'h46;
        bus.issue_en = 1'b1;
        bus.flush    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_issue_inst", 32'(bus.issue_inst), 32'h00);
            check("rst_in_ready", 32'(bus.in_ready), 32'h0);
        end
        @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.issue_en = 1'b0;
        @(negedge clk);
        check("post_rst_count", 32'(bus.count), 32'h0);
        check("post_rst_idle", 32'(bus.pipe_idle), 32'h1);
        check("post_rst_issued", 32'(bus.issued_cnt), 32'h0);

        // 2: two writes issued back to back after one cycle of latency
        drive(1'b1, 8'h46, 1'b1, 1'b0);
        check("t2_ready", 32'(bus.in_ready), 32'h1);
        check("t2_empty_nop", 32'(bus.issue_inst), 32'h00);
        drive(1'b1, 8'h9B, 1'b1, 1'b0);
        check("t2_issue0", 32'(bus.issue_inst), 32'h46);
        check("t2_write0", 32'(bus.issue_write), 32'h1);
        check("t2_count", 32'(bus.count), 32'h1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("t2_issue1", 32'(bus.issue_inst), 32'h9B);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("t2_nop", 32'(bus.issue_inst), 32'h00);
        check("t2_idle_ex", 32'(bus.pipe_idle), 32'h0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("t2_idle_wb", 32'(bus.pipe_idle), 32'h0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("t2_idle", 32'(bus.pipe_idle), 32'h1);
        check("t2_issued", 32'(bus.issued_cnt), 32'h2);

        // 3: fill to full with issue held, fifth word back-pressured
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h41 + 8'(i), 1'b0, 1'b0);
            check("t3_fill_ready", 32'(bus.in_ready), 32'h1);
            check("t3_fill_count", 32'(i), 32'(bus.count));
        end
        drive(1'b1, 8'h45, 1'b0, 1'b0);
        check("t3_full_ready", 32'(bus.in_ready), 32'h0);
        check("t3_full_count", 32'(bus.count), 32'h4);
        drive(1'b1, 8'h45, 1'b1, 1'b0);
        check("t3_fullpop_ready", 32'(bus.in_ready), 32'h0);
        check("t3_fullpop_inst", 32'(bus.issue_inst), 32'h41);
        drive(1'b1, 8'h45, 1'b0, 1'b0);
        check("t3_after_pop_ready", 32'(bus.in_ready), 32'h1);
        check("t3_after_pop_count", 32'(bus.count), 32'h3);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            check("t3_drain_inst", 32'(bus.issue_inst), 32'h42 + 32'(i));
            check("t3_drain_count", 32'(bus.count), 32'h4 - 32'(i));
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("t3_empty", 32'(bus.count), 32'h0);
        check("t3_issued", 32'(bus.issued_cnt), 32'h7);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("t3_idle", 32'(bus.pipe_idle), 32'h1);

        // 4: flush with a push while a write is in flight
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h81 + 8'(i), 1'b0, 1'b0);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("t4_issue", 32'(bus.issue_inst), 32'h81);
        check("t4_count", 32'(bus.count), 32'h3);
        drive(1'b1, 8'hC7, 1'b1, 1'b1);
        check("t4_flush_nop", 32'(bus.issue_inst), 32'h00);
        check("t4_flush_write", 32'(bus.issue_write), 32'h0);
        check("t4_flush_ready", 32'(bus.in_ready), 32'h0);
        check("t4_flush_idle", 32'(bus.pipe_idle), 32'h0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("t4_post_count", 32'(bus.count), 32'h0);
        check("t4_post_nop", 32'(bus.issue_inst), 32'h00);
        check("t4_post_idle", 32'(bus.pipe_idle), 32'h0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("t4_idle", 32'(bus.pipe_idle), 32'h1);
        check("t4_issued", 32'(bus.issued_cnt), 32'h8);

        // 5: push+pop every cycle across pointer wrap, with NOP-op words mixed in
        drive(1'b1, stream[0], 1'b0, 1'b0);
        for (int i = 1; i < 10; i++) begin
            drive(1'b1, stream[i], 1'b1, 1'b0);
            check("t5_order", 32'(bus.issue_inst), 32'(stream[i-1]));
            check("t5_write", 32'(bus.issue_write), 32'(stream[i-1][7:6] != 2'b00));
            check("t5_count", 32'(bus.count), 32'h1);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("t5_last", 32'(bus.issue_inst), 32'hC3);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("t5_empty", 32'(bus.count), 32'h0);
        check("t5_issued", 32'(bus.issued_cnt), 32'd15);

        // 6: issued_cnt wraps from all-ones to zero
        force dut.r_issued_cnt = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.r_issued_cnt;
        drive(1'b1, 8'h46, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("t6_issue", 32'(bus.issue_inst), 32'h46);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("t6_wrap", 32'(bus.issued_cnt), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
